// File: rtl/gpio8_in_debounce_if.sv
// GPIO8 input-conditioning bus: raw pads and controls in,
// filtered level and edge pulses out.
interface gpio8_in_debounce_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] pad_in;
  logic [CNT_W-1:0] db_len;
  logic [WIDTH-1:0] db_bypass;
  logic [WIDTH-1:0] io_in_clean;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;

  modport master (
    output pad_in,
    output db_len,
    output db_bypass,
    input  io_in_clean,
    input  rise_pulse,
    input  fall_pulse
  );

  modport slave (
    input  pad_in,
    input  db_len,
    input  db_bypass,
    output io_in_clean,
    output rise_pulse,
    output fall_pulse
  );
endinterface

// File: rtl/gpio8_in_debounce.sv
// Per-pin 2-flop synchroniser, programmable debounce filter
// and registered rise/fall pulse generation.
module gpio8_in_debounce #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic                CLK,
  input logic                RST,
  gpio8_in_debounce_if.slave bus
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] clean;
  logic [WIDTH-1:0] clean_next;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] byp;
  logic [WIDTH-1:0] eq;
  logic [WIDTH-1:0] done;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];

  assign byp = bus.db_bypass;
  assign eq  = ~(s2 ^ clean);

  always_comb begin
    done = '0;
    for (int i = 0; i < WIDTH; i++) begin
      done[i] = (cnt[i] >= bus.db_len);
    end
  end

  // Mismatch that ends before the count completes clears cnt.
  always_comb begin
    clean_next = clean;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      unique case (1'b1)
        byp[i]: begin
          clean_next[i] = s2[i];
        end
        ~byp[i] & eq[i]: begin
        end
        ~byp[i] & ~eq[i] & done[i]: begin
          clean_next[i] = s2[i];
        end
        ~byp[i] & ~eq[i] & ~done[i]: begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1     <= '0;
      s2     <= '0;
      clean  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1     <= bus.pad_in;
      s2     <= s1;
      clean  <= clean_next;
      rise_q <= ~clean & clean_next;
      fall_q <= clean & ~clean_next;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign bus.io_in_clean = clean;
  assign bus.rise_pulse  = rise_q;
  assign bus.fall_pulse  = fall_q;

endmodule

// File: tb/tb_gpio8_in_debounce.sv
// Directed bench for gpio8_in_debounce: reset, filter latency,
// glitch rejection, bypass, mid-count changes and db_len=0.
module tb_gpio8_in_debounce;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  gpio8_in_debounce_if #(.WIDTH(8), .CNT_W(8)) bus ();

  gpio8_in_debounce #(.WIDTH(8), .CNT_W(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each tick ends 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.pad_in    = '0;
    bus.db_bypass = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] exp;
    logic [23:0] obs;
    rst           = 1'b1;
    bus.pad_in    = 8'hFF;
    bus.db_bypass = 8'h00;
    bus.db_len    = 8'd4;
    for (int n = 1; n <= 3; n++) begin
      tick();
      obs = {bus.io_in_clean, bus.rise_pulse, bus.fall_pulse};
      checks++;
      if (obs !== 24'h0) begin
        failures++;
        $display("FAIL reset_hold n=%0d got=%h want=%h", n, obs, 24'h0);
      end
    end
    rst = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      tick();
      exp = {(n >= 7) ? 8'hFF : 8'h00,
             (n == 7) ? 8'hFF : 8'h00, 8'h00};
      obs = {bus.io_in_clean, bus.rise_pulse, bus.fall_pulse};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL reset_release n=%0d got=%h want=%h", n, obs, exp);
      end
    end
  endtask

  task automatic test_basic();
    logic [23:0] exp;
    logic [23:0] obs;
    do_reset();
    bus.db_len = 8'd10;
    bus.pad_in = 8'h08;
    for (int n = 1; n <= 15; n++) begin
      tick();
      exp = {(n >= 13) ? 8'h08 : 8'h00,
             (n == 13) ? 8'h08 : 8'h00, 8'h00};
      obs = {bus.io_in_clean, bus.rise_pulse, bus.fall_pulse};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL basic n=%0d got=%h want=%h", n, obs, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [23:0] exp;
    logic [23:0] obs;
    do_reset();
    bus.db_len = 8'd10;
    bus.pad_in = 8'h01;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 7) bus.pad_in = 8'h00;
      obs = {bus.io_in_clean, bus.rise_pulse, bus.fall_pulse};
      checks++;
      if (obs !== 24'h0) begin
        failures++;
        $display("FAIL glitch n=%0d got=%h want=%h", n, obs, 24'h0);
      end
    end
    bus.pad_in = 8'h01;
    for (int n = 1; n <= 15; n++) begin
      tick();
      exp = {(n >= 13) ? 8'h01 : 8'h00,
             (n == 13) ? 8'h01 : 8'h00, 8'h00};
      obs = {bus.io_in_clean, bus.rise_pulse, bus.fall_pulse};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL glitch_retry n=%0d got=%h want=%h", n, obs, exp);
      end
    end
  endtask

  task automatic test_bypass();
    logic [23:0] exp;
    logic [23:0] obs;
    do_reset();
    bus.db_bypass = 8'h0F;
    bus.db_len    = 8'd20;
    bus.pad_in    = 8'hFF;
    for (int n = 1; n <= 25; n++) begin
      tick();
      exp[23:16] = ((n >= 3) ? 8'h0F : 8'h00) |
                   ((n >= 23) ? 8'hF0 : 8'h00);
      exp[15:8]  = (n == 3) ? 8'h0F : ((n == 23) ? 8'hF0 : 8'h00);
      exp[7:0]   = 8'h00;
      obs = {bus.io_in_clean, bus.rise_pulse, bus.fall_pulse};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL bypass n=%0d got=%h want=%h", n, obs, exp);
      end
    end
    bus.db_bypass = 8'h00;
  endtask

  task automatic test_len_drop();
    logic [23:0] exp;
    logic [23:0] obs;
    do_reset();
    bus.db_len = 8'd50;
    bus.pad_in = 8'h80;
    for (int n = 1; n <= 17; n++) begin
      tick();
      // cnt[7] reaches 12 after tick 14
      if (n == 14) bus.db_len = 8'd5;
      exp = {(n >= 15) ? 8'h80 : 8'h00,
             (n == 15) ? 8'h80 : 8'h00, 8'h00};
      obs = {bus.io_in_clean, bus.rise_pulse, bus.fall_pulse};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL len_drop n=%0d got=%h want=%h", n, obs, exp);
      end
    end
  endtask

  task automatic test_reset_midcount();
    logic [23:0] exp;
    logic [23:0] obs;
    do_reset();
    bus.db_len = 8'd8;
    bus.pad_in = 8'h02;
    for (int n = 1; n <= 6; n++) tick();
    rst = 1'b1;
    tick();
    obs = {bus.io_in_clean, bus.rise_pulse, bus.fall_pulse};
    checks++;
    if (obs !== 24'h0) begin
      failures++;
      $display("FAIL rst_mid_hold got=%h want=%h", obs, 24'h0);
    end
    rst = 1'b0;
    for (int n = 1; n <= 13; n++) begin
      tick();
      exp = {(n >= 11) ? 8'h02 : 8'h00,
             (n == 11) ? 8'h02 : 8'h00, 8'h00};
      obs = {bus.io_in_clean, bus.rise_pulse, bus.fall_pulse};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL rst_mid n=%0d got=%h want=%h", n, obs, exp);
      end
    end
  endtask

  task automatic test_zero_len_pulse();
    logic [23:0] exp;
    logic [23:0] obs;
    do_reset();
    bus.db_len = 8'd0;
    bus.pad_in = 8'h20;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (n == 1) bus.pad_in = 8'h00;
      exp = {(n == 3) ? 8'h20 : 8'h00,
             (n == 3) ? 8'h20 : 8'h00,
             (n == 4) ? 8'h20 : 8'h00};
      obs = {bus.io_in_clean, bus.rise_pulse, bus.fall_pulse};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL zero_len n=%0d got=%h want=%h", n, obs, exp);
      end
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.pad_in    = '0;
    bus.db_len    = '0;
    bus.db_bypass = '0;
    test_reset();
    test_basic();
    test_glitch();
    test_bypass();
    test_len_drop();
    test_reset_midcount();
    test_zero_len_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
